pix_pair_packer: RTL and testbench
==================================

# pix_pair_packer

Write-side counterpart of the two-pixel unpacking path. It accepts one 24-bit RGB pixel per cycle, truncates each pixel to 6:6:6, and pairs even/odd pixels into the 36-bit two-pixel word that the pixel-pair consumers read. It computes the word address from the raster position, buffers completed words in a small FIFO, and drains them to the ZBT write port under a valid/ready handshake. It sits between the edge-detect output stream and the frame-buffer memory controller.

## Interface
- ADDR_W, 19, word address width; address is {vcount[9:0], hcount[9:1]}.
- FIFO_DEPTH, 4, number of buffered {addr, data} entries; must be a power of 2 and at least 2.
- clk  in  1  single system clock; all state is clocked on posedge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- pix_valid  in  1  pix_rgb/hcount/vcount valid this cycle.
- pix_rgb  in  24  {R[7:0], G[7:0], B[7:0]}.
- hcount  in  11  pixel column; bit 0 selects the half-word.
- vcount  in  10  pixel row.
- flush  in  1  push any held even pixel as a half-filled word.
- wr_valid  out  1  FIFO head is valid.
- wr_addr  out  ADDR_W  head word address.
- wr_data  out  36  head word.
- wr_ready  in  1  memory controller accepts the head this cycle.
- overflow  out  1  sticky; a completed word was dropped.
- orphan  out  1  sticky; a word was pushed with one half zero-filled.

## Operation
- Pixel truncation: p18 = {R[7:2], G[7:2], B[7:2]}.
- Word layout: the even pixel (hcount[0]=0) goes in [17:0] and the odd pixel in [35:18]. Within each half, R is at the top 6 bits and B at the bottom 6 bits.
- State machine has two states, IDLE and HELD. HELD stores the even p18, its hcount, and its vcount.
- In IDLE:
  - An even pixel stores its half and moves to HELD.
  - An odd pixel pushes {p18, 18'b0} at its own address, sets orphan, and stays in IDLE.
- In HELD:
  - An odd pixel with the same vcount and hcount = held hcount + 1 pushes {p18, held}. The address comes from the held pixel. Next state is IDLE.
  - An even pixel pushes {18'b0, held}, sets orphan, stores the new pixel, and stays in HELD.
  - A mismatched odd pixel pushes {18'b0, held} and sets orphan. The new odd pixel is then dropped and counted as an orphan; there is no second push. Next state is IDLE.
- flush is honoured only when pix_valid=0:
  - In HELD, it pushes {18'b0, held}, sets orphan, and moves to IDLE.
  - In IDLE, it has no effect.
- At most one push per cycle.
- FIFO:
  - Push and pop in the same cycle are legal at any occupancy, including full.
  - A push while full with no pop drops the word and sets overflow.
- overflow and orphan clear only on reset.

## Timing
- Reset values: wr_valid=0, wr_addr=0, wr_data=0, overflow=0, orphan=0, state=IDLE, FIFO empty.
- Latency: a completing pixel accepted at edge N gives wr_valid=1 with that word from edge N+1. wr_addr and wr_data are registered, with no combinational path from pix_* to wr_*.
- Handshake: a word transfers on an edge where wr_valid && wr_ready.
  - wr_addr and wr_data are stable while wr_valid=1 and wr_ready=0.
  - wr_ready=1 with wr_valid=0 does nothing.
- Sustained throughput is one word per two pixels, so with wr_ready held high the FIFO never exceeds one entry.
- Reset asserted mid-stream discards the held pixel and all FIFO contents. No partial word is emitted after release.

## Structure
- Shared package (pix_pkg):
  - PIX18_W=18 and WORD_W=36.
  - Function trunc666(rgb24) returning 18 bits.
  - Function pack_pair(odd18, even18) returning 36 bits.
  - The edge-detect path reuses the same definitions for unpacking.
- Sub-module pix_pair_fifo: synchronous FIFO with parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full. Data is ADDR_W+36 bits wide.

## Test plan
- Full pair: even pixel (h=10, v=3, rgb=24'hFC8004), then odd pixel (h=11, rgb=24'h0400FC), wr_ready=1. Expected: one cycle later wr_data={18'h0103F, 18'h3F801} (odd half in [35:18]), wr_addr={10'd3, 9'd5}, orphan=0.
- Backpressure/overflow: wr_ready=0, 5 complete pairs. Expected: wr_valid=1 with the first word held stable; overflow=1 after the 5th pair. Then wr_ready=1 drains exactly 4 words, in order.
- Simultaneous push/pop at full: FIFO full, wr_ready=1 on the cycle a pair completes. Expected: no overflow; occupancy stays 4.
- Orphans: even pixel h=20, then even pixel h=22. Expected: word {18'b0, pix20} at address h>>1=10, orphan=1. Then flush with pix_valid=0: pix22 pushed at address 11.
- Flush priority: flush=1 and pix_valid=1 with odd pixel h=23, while holding h=22. Expected: a single completed pair, no half word.
- Reset mid-operation: assert reset with 2 FIFO entries and a held pixel. Expected: outputs are 0 immediately, without waiting for a clock edge. After release, the first word out comes only from new pixels.

Source files
------------

// File: rtl/pix_pkg.sv
// Shared pixel definitions for the 6:6:6 two-pixel word used by the
// packing and unpacking paths.
package pix_pkg;

  localparam int unsigned PIX18_W = 18;
  localparam int unsigned WORD_W  = 36;

  typedef enum logic [0:0] {
    StIdle,
    StHeld
  } pack_state_e;

  // Keep the top 6 bits of each 8-bit channel; R ends up in the top bits.
  function automatic logic [PIX18_W-1:0] trunc666(input logic [23:0] rgb24);
    return {rgb24[23:18], rgb24[15:10], rgb24[7:2]};
  endfunction

  // Odd pixel occupies the upper half, even pixel the lower half.
  function automatic logic [WORD_W-1:0] pack_pair(input logic [PIX18_W-1:0] odd18,
                                                  input logic [PIX18_W-1:0] even18);
    return {odd18, even18};
  endfunction

endpackage

// File: rtl/pix_pair_packer_if.sv
// Pixel input stream and ZBT write port of the pixel-pair packer.
interface pix_pair_packer_if
  import pix_pkg::*;
#(
  parameter int unsigned ADDR_W = 19
);
  logic              pix_valid;
  logic [23:0]       pix_rgb;
  logic [10:0]       hcount;
  logic [9:0]        vcount;
  logic              flush;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  logic              overflow;
  logic              orphan;

  // Environment side: drives pixels and the write-port ready.
  modport master (
    output pix_valid, pix_rgb, hcount, vcount, flush, wr_ready,
    input  wr_valid, wr_addr, wr_data, overflow, orphan
  );

  // Packer side.
  modport slave (
    input  pix_valid, pix_rgb, hcount, vcount, flush, wr_ready,
    output wr_valid, wr_addr, wr_data, overflow, orphan
  );
endinterface

// File: rtl/pix_pair_fifo.sv
// Small synchronous FIFO; head entry is read straight from the storage
// registers so dout carries no path from din.
module pix_pair_fifo #(
  parameter int unsigned WIDTH = 55,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; reset clears contents so dout reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/pix_pair_packer.sv
// Packs even/odd 6:6:6 pixels into 36-bit words with raster-derived word
// addresses and queues them for the ZBT write port.
module pix_pair_packer
  import pix_pkg::*;
#(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  pix_pair_packer_if.slave bus
);

  localparam int unsigned EntW = ADDR_W + WORD_W;

  pack_state_e        state_q, state_d;
  logic [PIX18_W-1:0] held_pix_q, held_pix_d;
  logic [10:0]        held_h_q, held_h_d;
  logic [9:0]         held_v_q, held_v_d;
  logic               overflow_q, overflow_d;
  logic               orphan_q, orphan_d;

  logic [PIX18_W-1:0] p18;
  logic [ADDR_W-1:0]  pix_addr, held_addr;
  logic               pair_match;
  logic               push;
  logic               zero_fill;
  logic [ADDR_W-1:0]  push_addr;
  logic [WORD_W-1:0]  push_word;

  logic               fifo_empty, fifo_full, fifo_pop;
  logic [EntW-1:0]    fifo_dout;

  assign p18        = trunc666(bus.pix_rgb);
  assign pix_addr   = ADDR_W'({bus.vcount, bus.hcount[9:1]});
  assign held_addr  = ADDR_W'({held_v_q, held_h_q[9:1]});
  assign pair_match = (bus.vcount == held_v_q) && (bus.hcount == held_h_q + 11'd1);

  // Pairing decisions: at most one push per cycle; flush only on idle input.
  always_comb begin
    state_d    = state_q;
    held_pix_d = held_pix_q;
    held_h_d   = held_h_q;
    held_v_d   = held_v_q;
    push       = 1'b0;
    zero_fill  = 1'b0;
    push_addr  = '0;
    push_word  = '0;
    if (bus.pix_valid) begin
      unique case (state_q)
        StIdle: begin
          if (!bus.hcount[0]) begin
            held_pix_d = p18;
            held_h_d   = bus.hcount;
            held_v_d   = bus.vcount;
            state_d    = StHeld;
          end else begin
            push      = 1'b1;
            zero_fill = 1'b1;
            push_addr = pix_addr;
            push_word = pack_pair(p18, PIX18_W'(0));
          end
        end
        StHeld: begin
          push      = 1'b1;
          push_addr = held_addr;
          if (!bus.hcount[0]) begin
            // Back-to-back even pixels: emit the old one alone, hold the new.
            zero_fill  = 1'b1;
            push_word  = pack_pair(PIX18_W'(0), held_pix_q);
            held_pix_d = p18;
            held_h_d   = bus.hcount;
            held_v_d   = bus.vcount;
          end else if (pair_match) begin
            push_word = pack_pair(p18, held_pix_q);
            state_d   = StIdle;
          end else begin
            // Stray odd pixel is discarded after flushing the held half.
            zero_fill = 1'b1;
            push_word = pack_pair(PIX18_W'(0), held_pix_q);
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (bus.flush && (state_q == StHeld)) begin
      push      = 1'b1;
      zero_fill = 1'b1;
      push_addr = held_addr;
      push_word = pack_pair(PIX18_W'(0), held_pix_q);
      state_d   = StIdle;
    end
  end

  assign fifo_pop   = bus.wr_valid && bus.wr_ready;
  assign overflow_d = overflow_q || (push && fifo_full && !fifo_pop);
  assign orphan_d   = orphan_q || zero_fill;

  // Pairing state and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      held_pix_q <= '0;
      held_h_q   <= '0;
      held_v_q   <= '0;
      overflow_q <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_pix_q <= held_pix_d;
      held_h_q   <= held_h_d;
      held_v_q   <= held_v_d;
      overflow_q <= overflow_d;
      orphan_q   <= orphan_d;
    end
  end

  pix_pair_fifo #(
    .WIDTH (EntW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (fifo_pop),
    .din   ({push_addr, push_word}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.wr_valid = !fifo_empty;
  assign bus.wr_addr  = fifo_dout[EntW-1:WORD_W];
  assign bus.wr_data  = fifo_dout[WORD_W-1:0];
  assign bus.overflow = overflow_q;
  assign bus.orphan   = orphan_q;

endmodule

// File: tb/tb_pix_pair_packer.sv
// Bench for pix_pair_packer: directed scenarios plus random stimulus, checked
// every cycle against a queue-based model of the pairing rules.
module tb_pix_pair_packer;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   hs_cnt = 0;

  pix_pair_packer_if #(.ADDR_W(19)) bus ();

  pix_pair_packer #(
    .ADDR_W     (19),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [54:0] mq[$];
  bit          m_held = 0;
  logic [17:0] m_p = '0;
  int          m_h = 0;
  int          m_v = 0;
  bit          m_ovf = 0;
  bit          m_orph = 0;

  function automatic logic [17:0] m_trunc(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb) / 65536 % 256;
    g = int'(rgb) / 256 % 256;
    b = int'(rgb) % 256;
    return 18'((r / 4) * 4096 + (g / 4) * 64 + b / 4);
  endfunction

  function automatic logic [54:0] mk(input int h, input int v, input logic [35:0] w);
    int a;
    a = v * 512 + (h % 1024) / 2;
    return {19'(a), w};
  endfunction

  initial begin
    bit          do_push, pop_now;
    logic [54:0] ent;
    logic [17:0] p;
    int          h, v;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_held = 0;
        m_ovf  = 0;
        m_orph = 0;
      end else begin
        do_push = 0;
        ent     = '0;
        pop_now = (mq.size() != 0) && bus.wr_ready;
        p       = m_trunc(bus.pix_rgb);
        h       = int'(bus.hcount);
        v       = int'(bus.vcount);
        if (bus.pix_valid) begin
          if (h % 2 == 0) begin
            if (m_held) begin
              do_push = 1; ent = mk(m_h, m_v, {18'd0, m_p}); m_orph = 1;
            end
            m_held = 1; m_p = p; m_h = h; m_v = v;
          end else if (m_held && v == m_v && h == m_h + 1) begin
            do_push = 1; ent = mk(m_h, m_v, {p, m_p}); m_held = 0;
          end else if (m_held) begin
            do_push = 1; ent = mk(m_h, m_v, {18'd0, m_p}); m_orph = 1; m_held = 0;
          end else begin
            do_push = 1; ent = mk(h, v, {p, 18'd0}); m_orph = 1;
          end
        end else if (bus.flush && m_held) begin
          do_push = 1; ent = mk(m_h, m_v, {18'd0, m_p}); m_orph = 1; m_held = 0;
        end
        if (pop_now) void'(mq.pop_front());
        if (do_push) begin
          if (mq.size() < DEPTH) mq.push_back(ent);
          else m_ovf = 1;
        end
      end
    end
  end

  // Per-cycle comparison, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      check("wr_valid", bus.wr_valid, (mq.size() != 0));
      if (mq.size() != 0) begin
        check("wr_addr", bus.wr_addr, mq[0][54:36]);
        check("wr_data", bus.wr_data, mq[0][35:0]);
      end
      check("overflow", bus.overflow, m_ovf);
      check("orphan", bus.orphan, m_orph);
    end
  end

  // Count accepted transfers on the write port.
  initial begin
    forever begin
      @(posedge clk);
      if (rst_n && bus.wr_valid && bus.wr_ready) hs_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [23:0] rgb, input int h, input int vc,
                       input bit fl, input bit rdy);
    @(negedge clk);
    bus.pix_valid = v;
    bus.pix_rgb   = rgb;
    bus.hcount    = 11'(h);
    bus.vcount    = 10'(vc);
    bus.flush     = fl;
    bus.wr_ready  = rdy;
  endtask

  task automatic idle(input bit rdy);
    drive(0, 24'h0, 0, 0, 0, rdy);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int cur_h, cur_v;
    bus.pix_valid = 0;
    bus.pix_rgb   = '0;
    bus.hcount    = '0;
    bus.vcount    = '0;
    bus.flush     = 0;
    bus.wr_ready  = 0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check("rst wr_valid", bus.wr_valid, 0);
    check("rst wr_addr", bus.wr_addr, 0);
    check("rst wr_data", bus.wr_data, 0);
    check("rst overflow", bus.overflow, 0);
    check("rst orphan", bus.orphan, 0);
    @(negedge clk);
    rst_n = 1;

    // Full pair with hand-computed word and address
    drive(1, 24'hFC8004, 10, 3, 0, 1);
    drive(1, 24'h0400FC, 11, 3, 0, 1);
    after_edge();
    check("pair valid", bus.wr_valid, 1);
    check("pair data", bus.wr_data, {18'h0103F, 18'h3F801});
    check("pair addr", bus.wr_addr, {10'd3, 9'd5});
    check("pair orphan", bus.orphan, 0);
    idle(1);

    // Fill to 4, then complete a pair while popping: no overflow, 4 remain
    for (int k = 0; k < 4; k++) begin
      drive(1, 24'($urandom), 2 * k, 2, 0, 0);
      drive(1, 24'($urandom), 2 * k + 1, 2, 0, 0);
    end
    drive(1, 24'($urandom), 8, 2, 0, 0);
    drive(1, 24'($urandom), 9, 2, 0, 1);
    after_edge();
    base = hs_cnt;
    check("full push/pop overflow", bus.overflow, 0);
    repeat (6) idle(1);
    after_edge();
    check("full push/pop drained", hs_cnt - base, 4);

    // Backpressure: 5 pairs, overflow only on the 5th
    for (int k = 0; k < 5; k++) begin
      drive(1, 24'($urandom), 2 * k, 5, 0, 0);
      drive(1, 24'($urandom), 2 * k + 1, 5, 0, 0);
      after_edge();
      if (k == 3) check("ovf before 5th", bus.overflow, 0);
    end
    check("ovf after 5th", bus.overflow, 1);
    check("ovf valid held", bus.wr_valid, 1);
    base = hs_cnt;
    repeat (8) idle(1);
    after_edge();
    check("ovf drained", hs_cnt - base, 4);

    // Orphans: even then even, then flush the second
    drive(1, 24'h123456, 20, 7, 0, 1);
    drive(1, 24'h654321, 22, 7, 0, 1);
    after_edge();
    check("orphan flag", bus.orphan, 1);
    check("orphan addr", bus.wr_addr, {10'd7, 9'd10});
    check("orphan upper", bus.wr_data[35:18], 0);
    drive(0, 24'h0, 0, 0, 1, 1);
    after_edge();
    check("flush addr", bus.wr_addr, {10'd7, 9'd11});
    check("flush upper", bus.wr_data[35:18], 0);
    idle(1);

    // Flush ignored while a pixel is valid
    drive(1, 24'h040404, 22, 8, 0, 1);
    drive(1, 24'h808080, 23, 8, 1, 1);
    after_edge();
    check("flushprio data", bus.wr_data, {18'h20820, 18'h01041});
    check("flushprio addr", bus.wr_addr, {10'd8, 9'd11});
    idle(1);
    after_edge();
    check("flushprio single", bus.wr_valid, 0);

    // Random stream, mostly raster-ordered with occasional jumps
    cur_h = 0;
    cur_v = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 9) == 0) cur_h = $urandom_range(0, 2047);
        drive(1, 24'($urandom), cur_h, cur_v, $urandom_range(0, 1), $urandom_range(0, 2) != 0);
        cur_h = (cur_h + 1) % 2048;
        if (cur_h == 0) cur_v = (cur_v + 1) % 1024;
      end else begin
        drive(0, 24'($urandom), 0, 0, $urandom_range(0, 1), $urandom_range(0, 1));
      end
    end
    drive(0, 24'h0, 0, 0, 1, 1);
    repeat (6) idle(1);

    // Reset mid-operation: 2 entries queued plus a held even pixel
    drive(1, 24'($urandom), 0, 9, 0, 0);
    drive(1, 24'($urandom), 1, 9, 0, 0);
    drive(1, 24'($urandom), 2, 9, 0, 0);
    drive(1, 24'($urandom), 3, 9, 0, 0);
    drive(1, 24'($urandom), 4, 9, 0, 0);
    drive(0, 24'h0, 0, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("midrst wr_valid", bus.wr_valid, 0);
    check("midrst wr_addr", bus.wr_addr, 0);
    check("midrst wr_data", bus.wr_data, 0);
    check("midrst overflow", bus.overflow, 0);
    check("midrst orphan", bus.orphan, 0);
    @(negedge clk);
    rst_n = 1;
    drive(1, 24'hFFFFFF, 5, 9, 0, 1);
    after_edge();
    check("postrst data", bus.wr_data, {18'h3FFFF, 18'h0});
    check("postrst addr", bus.wr_addr, {10'd9, 9'd2});
    drive(1, 24'($urandom), 6, 9, 0, 1);
    drive(1, 24'($urandom), 7, 9, 0, 1);
    repeat (4) idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
